interrupt_scheduler: RTL and testbench
======================================

Name: interrupt_scheduler

Overview:
- Arbitrates among NUM_SRC level-sensitive interrupt sources and presents at most one interrupt at a time to the global control unit.
- Drives gc's interrupt_pending input and returns gc's interrupt_taken acknowledgement.
- Filters short glitches with a settle window, latches a stable cause code, and enforces a holdoff gap after each taken interrupt so the pipeline can drain before the next one.

Parameters:
- NUM_SRC, 8, number of interrupt sources (2..32).
- SETTLE_CYCLES, 2, cycles a source must stay active before presentation (0..15).
- HOLDOFF_CYCLES, 4, minimum cycles after a take before a new request may start settling (0..15).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- irq_src  in  NUM_SRC  raw level interrupt requests.
- irq_enable  in  NUM_SRC  per-source enable mask.
- global_enable  in  1  global interrupt enable (mstatus.MIE-equivalent).
- interrupt_taken  in  1  pulse from gc: presented interrupt accepted.
- interrupt_pending  out  1  request to gc, registered.
- interrupt_cause  out  5  index of the presented source, registered.
- sched_busy  out  1  high in any state other than IDLE.

Behaviour:
- active = irq_src & irq_enable, with every bit gated by global_enable.
- Reset: state IDLE; interrupt_pending=0; interrupt_cause=0; sched_busy=0; counter=0; rr_ptr=0.
- A reset asserted mid-operation returns to IDLE in the next cycle with all outputs 0.
- States:
  - IDLE: if |active, go to SETTLE with counter=0. If SETTLE_CYCLES==0, go straight to PRESENT and latch the winner.
  - SETTLE: counter+1 per cycle.
    - If active==0, return to IDLE.
    - At counter==SETTLE_CYCLES-1 with |active, go to PRESENT and latch the winner index into interrupt_cause.
  - PRESENT: interrupt_pending=1 from the first cycle in the state. interrupt_cause is held constant; there is no preemption by a higher-priority source.
    - If interrupt_taken: go to HOLDOFF; interrupt_pending=0 in the next cycle.
    - Else if active[interrupt_cause]==0: withdraw and go to IDLE; interrupt_pending=0 in the next cycle.
    - If taken and withdraw occur in the same cycle, taken wins (go to HOLDOFF).
  - HOLDOFF: counter counts HOLDOFF_CYCLES cycles, then IDLE. If HOLDOFF_CYCLES==0, PRESENT goes directly to IDLE on a take.
- Latency: a source held from cycle 0 produces interrupt_pending=1 at cycle SETTLE_CYCLES+1.
- Winner selection: lowest-index set bit of active (fixed priority).
- interrupt_taken outside PRESENT is ignored: no state change, no rr_ptr update.
- global_enable dropping during PRESENT clears active, so the request withdraws unless a take arrives in the same cycle.
- Counter is 4 bits and saturates; it never wraps.
- interrupt_cause retains its last value in IDLE/SETTLE/HOLDOFF.
- sched_busy is combinational from state.

Optional Feature:
- Macro: INTERRUPT_SCHEDULER_ROUND_ROBIN_EN.
- Defined: the winner is the first set bit of active scanning upward from rr_ptr, with wrap-around. On each take, rr_ptr <= (interrupt_cause+1) mod NUM_SRC.
- Undefined: fixed lowest-index priority; rr_ptr logic is absent.

Decomposition:
- Shared package (csr_types): irq_cause_t (5-bit); interrupt_sched_state_t enum {IDLE, SETTLE, PRESENT, HOLDOFF}; constant MAX_IRQ_SRC=32.
- One sub-module: irq_priority_picker. Combinational find-first with an optional rotate base input; outputs a valid flag and an index. Reusable for exception-source selection.

Test Plan:
- Reset release, irq_src=0 for 10 cycles -> interrupt_pending=0, sched_busy=0, cause=0 throughout.
- irq_src=8'h0C, enable=8'hFF, global_enable=1 from cycle 0 -> pending rises at cycle 3, cause=2. Taken pulse at cycle 5 -> pending=0 at cycle 6, busy until HOLDOFF ends at cycle 10.
- Source 1 pulsed high for 1 cycle only (SETTLE_CYCLES=2) -> returns to IDLE, pending never asserts.
- In PRESENT with cause=3, deassert irq_src[3] and assert interrupt_taken in the same cycle -> HOLDOFF entered, taken honoured.
- In PRESENT, drop global_enable with no take -> pending=0 next cycle, state IDLE. A stray interrupt_taken in IDLE causes no change.
- With INTERRUPT_SCHEDULER_ROUND_ROBIN_EN, irq_src=8'h05 held, each present taken immediately -> cause sequence 0, 2, 0, 2. Without the macro -> 0, 0, 0, 0.

Source files
------------

// File: rtl/csr_types.sv
// Shared CSR/interrupt types: cause code width, scheduler state encoding and
// the architectural upper bound on interrupt sources.
package csr_types;
  localparam int MAX_IRQ_SRC = 32;

  typedef logic [4:0] irq_cause_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    PRESENT = 2'd2,
    HOLDOFF = 2'd3
  } interrupt_sched_state_t;
endpackage

// File: rtl/irq_priority_picker.sv
// Combinational find-first over a request vector, starting at a rotate base
// and wrapping around; base = 0 gives plain lowest-index priority.
module irq_priority_picker
  import csr_types::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] req,
  input  irq_cause_t   base,
  output logic         valid,
  output irq_cause_t   idx
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] shifted;
  logic [N-1:0]   rot;
  logic [5:0]     sum;

  // Rotating a doubled copy right by base puts source 'base' at bit 0.
  always_comb begin
    dbl     = {req, req};
    shifted = dbl >> base;
    rot     = shifted[N-1:0];
  end

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    sum   = '0;
    for (int i = 0; i < N; i++) begin
      if (!valid && rot[i]) begin
        valid = 1'b1;
        sum   = 6'(base) + 6'(i);
        if (sum >= 6'(N)) sum = sum - 6'(N);
        idx   = sum[4:0];
      end
    end
  end

endmodule

// File: rtl/interrupt_scheduler.sv
// Interrupt scheduler: settles, latches and presents one interrupt to gc, then
// enforces a holdoff gap. Define INTERRUPT_SCHEDULER_ROUND_ROBIN_EN for rotating priority.
module interrupt_scheduler
  import csr_types::*;
#(
  parameter int NUM_SRC        = 8,
  parameter int SETTLE_CYCLES  = 2,
  parameter int HOLDOFF_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_SRC-1:0]     irq_src,
  input  logic [NUM_SRC-1:0]     irq_enable,
  input  logic                   global_enable,
  input  logic                   interrupt_taken,
  output logic                   interrupt_pending,
  output irq_cause_t             interrupt_cause,
  output logic                   sched_busy,
  output interrupt_sched_state_t state_dbg
);

  // Handshake: interrupt_pending is a level request held for the whole PRESENT
  // state; gc answers with a one-cycle interrupt_taken while pending is high.
  // A take seen outside PRESENT is ignored.

  localparam logic [3:0] SETTLE_LAST  = 4'(SETTLE_CYCLES  > 0 ? SETTLE_CYCLES  - 1 : 0);
  localparam logic [3:0] HOLDOFF_LAST = 4'(HOLDOFF_CYCLES > 0 ? HOLDOFF_CYCLES - 1 : 0);

  interrupt_sched_state_t state, state_n;
  logic [3:0]             counter, counter_n, counter_inc;
  logic                   pending_n;
  irq_cause_t             cause_n;
  logic [NUM_SRC-1:0]     active;
  logic [MAX_IRQ_SRC-1:0] active_ext;
  logic                   win_valid;
  irq_cause_t             win_idx;
  irq_cause_t             pick_base;

  always_comb begin
    active     = irq_src & irq_enable & {NUM_SRC{global_enable}};
    active_ext = '0;
    active_ext[NUM_SRC-1:0] = active;
  end

`ifdef INTERRUPT_SCHEDULER_ROUND_ROBIN_EN
  irq_cause_t rr_ptr, rr_ptr_n;
  assign pick_base = rr_ptr;
`else
  assign pick_base = '0;
`endif

  irq_priority_picker #(.N(NUM_SRC)) u_picker (
    .req   (active),
    .base  (pick_base),
    .valid (win_valid),
    .idx   (win_idx)
  );

  assign counter_inc = (counter == 4'hF) ? counter : counter + 4'd1;
  assign sched_busy  = (state != IDLE);
  assign state_dbg   = state;

  always_comb begin
    state_n   = state;
    counter_n = counter;
    pending_n = interrupt_pending;
    cause_n   = interrupt_cause;
`ifdef INTERRUPT_SCHEDULER_ROUND_ROBIN_EN
    rr_ptr_n  = rr_ptr;
`endif
    case (state)
      IDLE: begin
        if (win_valid) begin
          if (SETTLE_CYCLES == 0) begin
            state_n   = PRESENT;
            pending_n = 1'b1;
            cause_n   = win_idx;
          end else begin
            state_n   = SETTLE;
            counter_n = 4'd0;
          end
        end
      end
      SETTLE: begin
        if (!win_valid) begin
          state_n = IDLE;
        end else if (counter == SETTLE_LAST) begin
          state_n   = PRESENT;
          pending_n = 1'b1;
          cause_n   = win_idx;
        end else begin
          counter_n = counter_inc;
        end
      end
      PRESENT: begin
        // A take in the same cycle as a withdraw is still honoured.
        if (interrupt_taken) begin
          pending_n = 1'b0;
          counter_n = 4'd0;
          state_n   = (HOLDOFF_CYCLES == 0) ? IDLE : HOLDOFF;
`ifdef INTERRUPT_SCHEDULER_ROUND_ROBIN_EN
          rr_ptr_n  = (interrupt_cause == 5'(NUM_SRC - 1)) ? '0 : interrupt_cause + 5'd1;
`endif
        end else if (!active_ext[interrupt_cause]) begin
          pending_n = 1'b0;
          state_n   = IDLE;
        end
      end
      HOLDOFF: begin
        if (counter == HOLDOFF_LAST) state_n = IDLE;
        else                         counter_n = counter_inc;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      counter           <= 4'd0;
      interrupt_pending <= 1'b0;
      interrupt_cause   <= '0;
`ifdef INTERRUPT_SCHEDULER_ROUND_ROBIN_EN
      rr_ptr            <= '0;
`endif
    end else begin
      state             <= state_n;
      counter           <= counter_n;
      interrupt_pending <= pending_n;
      interrupt_cause   <= cause_n;
`ifdef INTERRUPT_SCHEDULER_ROUND_ROBIN_EN
      rr_ptr            <= rr_ptr_n;
`endif
    end
  end

endmodule

// File: tb/tb_interrupt_scheduler.sv
// Self-checking bench for interrupt_scheduler (default parameters); expected
// causes go into a scoreboard queue and are compared on each pending rise.
module tb_interrupt_scheduler;
  import csr_types::*;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [7:0]             irq_src;
  logic [7:0]             irq_enable;
  logic                   global_enable;
  logic                   interrupt_taken;
  logic                   interrupt_pending;
  logic [4:0]             interrupt_cause;
  logic                   sched_busy;
  interrupt_sched_state_t state_dbg;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [4:0] exp_q[$];
  logic [4:0] rr_exp[4];
  logic       prev_pend = 1'b0;

  interrupt_scheduler #(
    .NUM_SRC(8), .SETTLE_CYCLES(2), .HOLDOFF_CYCLES(4)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .irq_src           (irq_src),
    .irq_enable        (irq_enable),
    .global_enable     (global_enable),
    .interrupt_taken   (interrupt_taken),
    .interrupt_pending (interrupt_pending),
    .interrupt_cause   (interrupt_cause),
    .sched_busy        (sched_busy),
    .state_dbg         (state_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic pend, input logic busy);
    check_eq({tag, "_pend"}, interrupt_pending, pend);
    check_eq({tag, "_busy"}, sched_busy, busy);
  endtask

  task automatic check_state(input string tag, input interrupt_sched_state_t s);
    check_eq({tag, "_state"}, state_dbg, s);
  endtask

  task automatic wait_pending(input string tag, input int budget);
    for (int i = 0; i < budget && !interrupt_pending; i++) tick();
    check_eq({tag, "_wait"}, interrupt_pending, 1'b1);
  endtask

  // scoreboard: compare latched cause on every rising edge of pending
  always @(negedge clk) begin
    if (interrupt_pending && !prev_pend) begin
      if (exp_q.size() == 0) check_eq("sb_unexpected", exp_q.size(), 1);
      else                   check_eq("sb_cause", interrupt_cause, exp_q.pop_front());
    end
    prev_pend = interrupt_pending;
  end

  initial begin
    rst = 1'b1; irq_src = '0; irq_enable = 8'hFF; global_enable = 1'b1; interrupt_taken = 1'b0;
    tick(3);
    check_out("rst", 1'b0, 1'b0);
    check_eq("rst_cause", interrupt_cause, 0);
    rst = 1'b0;

    // idle with no requests
    for (int i = 0; i < 10; i++) begin
      tick();
      check_out("idle", 1'b0, 1'b0);
      check_eq("idle_cause", interrupt_cause, 0);
    end

    // 0x0C: cause 2 presented at cycle 3, taken at 5, holdoff 6..9
    irq_src = 8'h0C; exp_q.push_back(5'd2);
    tick(); check_out("s2_c1", 1'b0, 1'b1);
    tick(); check_out("s2_c2", 1'b0, 1'b1);
    tick(); check_out("s2_c3", 1'b1, 1'b1); check_eq("s2_c3_cause", interrupt_cause, 2);
    tick(); check_out("s2_c4", 1'b1, 1'b1);
    tick(); check_out("s2_c5", 1'b1, 1'b1);
    interrupt_taken = 1'b1;
    tick(); interrupt_taken = 1'b0; irq_src = '0;
    check_out("s2_c6", 1'b0, 1'b1); check_state("s2_c6", HOLDOFF);
    check_eq("s2_c6_cause", interrupt_cause, 2);
    for (int c = 7; c <= 9; c++) begin
      tick(); check_out("s2_hold", 1'b0, 1'b1);
    end
    tick(); check_out("s2_c10", 1'b0, 1'b0); check_state("s2_c10", IDLE);

    // single-cycle glitch on source 1 never presents
    irq_src = 8'h02;
    tick(); irq_src = '0; check_state("s3_c1", SETTLE);
    tick(); check_out("s3_c2", 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(); check_out("s3_quiet", 1'b0, 1'b0);
    end

    // withdraw and take together: take wins
    irq_src = 8'h08; exp_q.push_back(5'd3);
    tick(3); check_out("s4_pres", 1'b1, 1'b1); check_eq("s4_cause", interrupt_cause, 3);
    irq_src = '0; interrupt_taken = 1'b1;
    tick(); interrupt_taken = 1'b0;
    check_out("s4_take", 1'b0, 1'b1); check_state("s4_take", HOLDOFF);
    tick(4); check_state("s4_end", IDLE);

    // global_enable drop withdraws; stray take in IDLE is ignored
    irq_src = 8'h10; exp_q.push_back(5'd4);
    tick(3); check_out("s5_pres", 1'b1, 1'b1); check_eq("s5_cause", interrupt_cause, 4);
    global_enable = 1'b0;
    tick(); check_out("s5_wd", 1'b0, 1'b0); check_state("s5_wd", IDLE);
    interrupt_taken = 1'b1;
    tick(); interrupt_taken = 1'b0;
    check_state("s5_stray", IDLE); check_out("s5_stray", 1'b0, 1'b0);
    check_eq("s5_keep_cause", interrupt_cause, 4);
    irq_src = '0; global_enable = 1'b1;
    tick();

    // reset mid-operation
    irq_src = 8'h01; exp_q.push_back(5'd0);
    tick(3); check_out("s6_pres", 1'b1, 1'b1);
    rst = 1'b1;
    tick(); check_out("s6_rst", 1'b0, 1'b0); check_state("s6_rst", IDLE);
    check_eq("s6_rst_cause", interrupt_cause, 0);
    rst = 1'b0; irq_src = '0;
    tick(2); check_state("s6_after", IDLE);

    // repeated takes with 0x05 held
`ifdef INTERRUPT_SCHEDULER_ROUND_ROBIN_EN
    rr_exp[0] = 5'd0; rr_exp[1] = 5'd2; rr_exp[2] = 5'd0; rr_exp[3] = 5'd2;
`else
    rr_exp[0] = 5'd0; rr_exp[1] = 5'd0; rr_exp[2] = 5'd0; rr_exp[3] = 5'd0;
`endif
    for (int r = 0; r < 4; r++) exp_q.push_back(rr_exp[r]);
    irq_src = 8'h05;
    for (int r = 0; r < 4; r++) begin
      wait_pending("rr", 20);
      check_eq("rr_cause", interrupt_cause, rr_exp[r]);
      interrupt_taken = 1'b1;
      tick(); interrupt_taken = 1'b0;
      check_out("rr_take", 1'b0, 1'b1);
    end
    irq_src = '0;
    tick(10);
    check_state("final", IDLE);
    check_eq("sb_leftover", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
